// File: rtl/bus_arbiter.sv
// Arbitrates the external memory bus between instruction fetch and the data port,
// with store lane steering and load extension. Optional macro: BUS_ARBITER_ROUND_ROBIN_EN.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_request,
  input  logic [31:0] fetch_address,
  output logic        fetch_ready,
  output logic [31:0] fetch_data,
  output logic        fetch_error,
  input  logic        data_load,
  input  logic        data_store,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_size,
  input  logic        data_signed,
  input  logic [31:0] data_store_data,
  output logic        data_ready,
  output logic [31:0] data_load_data,
  output logic        data_error,
  output logic [31:0] ext_address,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  output logic        ext_read_request,
  output logic        ext_write_request,
  input  logic        ext_ready,
  input  logic [31:0] ext_read_data
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_next;
  logic             data_req_c;
  logic             grant_c;
  logic             grant_to_data_c;
  logic             done_c;
  logic             abort_c;
  logic             timeout_hit_c;
  logic [3:0]       store_strobe_c;
  logic [31:0]      store_data_c;

  logic             owner_data;
  logic             lat_write;
  logic [1:0]       lat_lane;
  logic [1:0]       lat_size;
  logic             lat_signed;
  logic [CNT_W-1:0] cnt;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic             last_grant_data;
`endif

  assign data_req_c    = data_load | data_store;
  assign timeout_hit_c = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) >= TIMEOUT);

  // Select the byte lane of the returned word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   load_extend = {{24{sgn & b[7]}}, b};
      2'b01:   load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = w;
    endcase
  endfunction

  always_comb begin
    store_strobe_c = 4'b0000;
    store_data_c   = data_store_data;
    case (data_size)
      2'b00: begin
        store_strobe_c = 4'b0001 << data_address[1:0];
        store_data_c   = {4{data_store_data[7:0]}};
      end
      2'b01: begin
        store_strobe_c = 4'b0011 << {data_address[1], 1'b0};
        store_data_c   = {2{data_store_data[15:0]}};
      end
      2'b10:   store_strobe_c = 4'b1111;
      default: store_strobe_c = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    grant_c         = 1'b0;
    grant_to_data_c = 1'b0;
    done_c          = 1'b0;
    abort_c         = 1'b0;
    case (state)
      IDLE: begin
        if (data_req_c || fetch_request) begin
          grant_c    = 1'b1;
          state_next = BUSY;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
          grant_to_data_c = data_req_c && (!fetch_request || !last_grant_data);
`else
          grant_to_data_c = data_req_c;
`endif
        end
      end
      BUSY: begin
        if (ext_ready) begin
          done_c     = 1'b1;
          state_next = RESP;
        end else if (timeout_hit_c) begin
          abort_c    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches, bus drive and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_ready       <= 1'b0;
      fetch_data        <= 32'd0;
      fetch_error       <= 1'b0;
      data_ready        <= 1'b0;
      data_load_data    <= 32'd0;
      data_error        <= 1'b0;
      ext_address       <= 32'd0;
      ext_write_data    <= 32'd0;
      ext_write_strobe  <= 4'b0000;
      ext_read_request  <= 1'b0;
      ext_write_request <= 1'b0;
      owner_data        <= 1'b0;
      lat_write         <= 1'b0;
      lat_lane          <= 2'd0;
      lat_size          <= 2'd0;
      lat_signed        <= 1'b0;
      cnt               <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      last_grant_data   <= 1'b1;
`endif
    end else begin
      fetch_ready <= 1'b0;
      fetch_error <= 1'b0;
      data_ready  <= 1'b0;
      data_error  <= 1'b0;
      if (grant_c) begin
        owner_data <= grant_to_data_c;
        cnt        <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        last_grant_data <= grant_to_data_c;
`endif
        if (grant_to_data_c) begin
          ext_address       <= {data_address[31:2], 2'b00};
          ext_write_request <= data_store;
          ext_read_request  <= ~data_store;
          ext_write_strobe  <= data_store ? store_strobe_c : 4'b0000;
          ext_write_data    <= data_store ? store_data_c : 32'd0;
          lat_write         <= data_store;
          lat_lane          <= data_address[1:0];
          lat_size          <= data_size;
          lat_signed        <= data_signed;
        end else begin
          ext_address       <= fetch_address & 32'hFFFF_FFFC;
          ext_read_request  <= 1'b1;
          ext_write_request <= 1'b0;
          ext_write_strobe  <= 4'b0000;
          ext_write_data    <= 32'd0;
          lat_write         <= 1'b0;
        end
      end
      if (state == BUSY && !done_c && !abort_c && TIMEOUT != 0)
        cnt <= cnt + CNT_W'(1);
      if (done_c || abort_c) begin
        ext_read_request  <= 1'b0;
        ext_write_request <= 1'b0;
        if (owner_data) begin
          data_ready <= 1'b1;
          data_error <= abort_c;
          if (abort_c)
            data_load_data <= 32'd0;
          else if (!lat_write)
            data_load_data <= load_extend(ext_read_data, lat_lane, lat_size, lat_signed);
        end else begin
          fetch_ready <= 1'b1;
          fetch_error <= abort_c;
          fetch_data  <= abort_c ? 32'd0 : ext_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (built with TIMEOUT=4).
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        fetch_error;
  logic        data_load;
  logic        data_store;
  logic [31:0] data_address;
  logic [1:0]  data_size;
  logic        data_signed;
  logic [31:0] data_store_data;
  logic        data_ready;
  logic [31:0] data_load_data;
  logic        data_error;
  logic [31:0] ext_address;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_write_strobe;
  logic        ext_read_request;
  logic        ext_write_request;
  logic        ext_ready;
  logic [31:0] ext_read_data;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data), .fetch_error(fetch_error),
    .data_load(data_load), .data_store(data_store), .data_address(data_address),
    .data_size(data_size), .data_signed(data_signed), .data_store_data(data_store_data),
    .data_ready(data_ready), .data_load_data(data_load_data), .data_error(data_error),
    .ext_address(ext_address), .ext_write_data(ext_write_data),
    .ext_write_strobe(ext_write_strobe), .ext_read_request(ext_read_request),
    .ext_write_request(ext_write_request), .ext_ready(ext_ready),
    .ext_read_data(ext_read_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_request = 1'b0; fetch_address = '0;
    data_load = 1'b0; data_store = 1'b0; data_address = '0;
    data_size = '0; data_signed = 1'b0; data_store_data = '0;
    ext_ready = 1'b0; ext_read_data = '0;
    tick(); tick();
    checks++;
    if ({fetch_ready, fetch_data, fetch_error, data_ready, data_load_data, data_error,
         ext_address, ext_write_data, ext_write_strobe, ext_read_request, ext_write_request} !== '0)
      $display("FAIL reset_outputs: some output nonzero during reset");
    else passes++;
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({ext_read_request, ext_write_request, fetch_ready, data_ready} !== 4'b0000)
      $display("FAIL idle_no_request: got %b expected 0000",
               {ext_read_request, ext_write_request, fetch_ready, data_ready});
    else passes++;
  endtask

  task automatic test_fetch();
    fetch_request = 1'b1; fetch_address = 32'h100;
    tick();
    fetch_request = 1'b0;
    checks++;
    if (ext_read_request !== 1'b1 || ext_address !== 32'h100 || fetch_ready !== 1'b0)
      $display("FAIL fetch_bus: rd=%b addr=%h rdy=%b expected 1 00000100 0",
               ext_read_request, ext_address, fetch_ready);
    else passes++;
    ext_ready = 1'b1; ext_read_data = 32'h0000_0013;
    tick();
    ext_ready = 1'b0; ext_read_data = '0;
    checks++;
    if (fetch_ready !== 1'b1 || fetch_data !== 32'h13 || fetch_error !== 1'b0 || ext_read_request !== 1'b0)
      $display("FAIL fetch_resp: rdy=%b data=%h err=%b rd=%b expected 1 00000013 0 0",
               fetch_ready, fetch_data, fetch_error, ext_read_request);
    else passes++;
    tick();
    checks++;
    if (fetch_ready !== 1'b0 || fetch_data !== 32'h13)
      $display("FAIL fetch_hold: rdy=%b data=%h expected 0 00000013", fetch_ready, fetch_data);
    else passes++;
  endtask

  task automatic test_store();
    data_store = 1'b1; data_load = 1'b1; data_address = 32'h203; data_size = 2'b00;
    data_store_data = 32'h0000_00AB;
    tick();
    data_store = 1'b0; data_load = 1'b0;
    checks++;
    if (ext_write_request !== 1'b1 || ext_read_request !== 1'b0 || ext_address !== 32'h200 ||
        ext_write_strobe !== 4'b1000 || ext_write_data !== 32'hABABABAB)
      $display("FAIL store_byte_bus: wr=%b rd=%b addr=%h strb=%b wdata=%h expected 1 0 00000200 1000 abababab",
               ext_write_request, ext_read_request, ext_address, ext_write_strobe, ext_write_data);
    else passes++;
    data_address = 32'hFFF; data_store_data = 32'h1111_1111; data_store = 1'b1;
    tick();
    data_store = 1'b0;
    checks++;
    if (ext_address !== 32'h200 || ext_write_data !== 32'hABABABAB || ext_write_request !== 1'b1)
      $display("FAIL busy_ignores_inputs: addr=%h wdata=%h wr=%b expected 00000200 abababab 1",
               ext_address, ext_write_data, ext_write_request);
    else passes++;
    ext_ready = 1'b1;
    tick();
    ext_ready = 1'b0;
    checks++;
    if (data_ready !== 1'b1 || data_error !== 1'b0 || fetch_ready !== 1'b0 || ext_write_request !== 1'b0)
      $display("FAIL store_byte_resp: drdy=%b derr=%b frdy=%b wr=%b expected 1 0 0 0",
               data_ready, data_error, fetch_ready, ext_write_request);
    else passes++;
    tick();
    data_store = 1'b1; data_address = 32'h202; data_size = 2'b01; data_store_data = 32'h1234_CDEF;
    tick();
    data_store = 1'b0;
    checks++;
    if (ext_write_strobe !== 4'b1100 || ext_write_data !== 32'hCDEFCDEF || ext_address !== 32'h200)
      $display("FAIL store_half_bus: strb=%b wdata=%h addr=%h expected 1100 cdefcdef 00000200",
               ext_write_strobe, ext_write_data, ext_address);
    else passes++;
    ext_ready = 1'b1;
    tick();
    ext_ready = 1'b0;
    tick();
  endtask

  logic [31:0] ld_addr [5] = '{32'h302, 32'h302, 32'h301, 32'h303, 32'h300};
  logic [1:0]  ld_size [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b11};
  logic        ld_sgn  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] ld_exp  [5] = '{32'hFFFF8001, 32'h00008001, 32'h00000012, 32'hFFFFFF80, 32'h80011234};

  task automatic test_load();
    for (int i = 0; i < 5; i++) begin
      data_load = 1'b1; data_address = ld_addr[i]; data_size = ld_size[i]; data_signed = ld_sgn[i];
      tick();
      data_load = 1'b0;
      checks++;
      if (ext_address !== 32'h300 || ext_read_request !== 1'b1)
        $display("FAIL load_bus[%0d]: addr=%h rd=%b expected 00000300 1", i, ext_address, ext_read_request);
      else passes++;
      ext_ready = 1'b1; ext_read_data = 32'h8001_1234;
      tick();
      ext_ready = 1'b0; ext_read_data = '0;
      checks++;
      if (data_ready !== 1'b1 || data_load_data !== ld_exp[i])
        $display("FAIL load_result[%0d]: rdy=%b data=%h expected 1 %h", i, data_ready, data_load_data, ld_exp[i]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_arbitration();
    logic first_is_data;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    first_is_data = 1'b0;
`else
    first_is_data = 1'b1;
`endif
    fetch_request = 1'b1; fetch_address = 32'h400;
    data_load = 1'b1; data_address = 32'h500; data_size = 2'b10; data_signed = 1'b0;
    tick();
    checks++;
    if (ext_address !== (first_is_data ? 32'h500 : 32'h400))
      $display("FAIL arb_first_grant: addr=%h expected %h", ext_address, first_is_data ? 32'h500 : 32'h400);
    else passes++;
    ext_ready = 1'b1; ext_read_data = 32'hCAFE_F00D;
    tick();
    ext_ready = 1'b0; ext_read_data = '0;
    checks++;
    if ({fetch_ready, data_ready} !== (first_is_data ? 2'b01 : 2'b10))
      $display("FAIL arb_first_ready: fetch/data ready=%b expected %b",
               {fetch_ready, data_ready}, first_is_data ? 2'b01 : 2'b10);
    else passes++;
    if (first_is_data) data_load = 1'b0;
    else fetch_request = 1'b0;
    tick();
    checks++;
    if (ext_read_request !== 1'b0 || fetch_ready !== 1'b0 || data_ready !== 1'b0)
      $display("FAIL arb_gap: rd=%b frdy=%b drdy=%b expected 0 0 0", ext_read_request, fetch_ready, data_ready);
    else passes++;
    tick();
    fetch_request = 1'b0; data_load = 1'b0;
    checks++;
    if (ext_address !== (first_is_data ? 32'h400 : 32'h500) || ext_read_request !== 1'b1)
      $display("FAIL arb_second_grant: addr=%h rd=%b expected %h 1",
               ext_address, ext_read_request, first_is_data ? 32'h400 : 32'h500);
    else passes++;
    ext_ready = 1'b1; ext_read_data = 32'h1111_2222;
    tick();
    ext_ready = 1'b0; ext_read_data = '0;
    checks++;
    if ({fetch_ready, data_ready} !== (first_is_data ? 2'b10 : 2'b01))
      $display("FAIL arb_second_ready: fetch/data ready=%b expected %b",
               {fetch_ready, data_ready}, first_is_data ? 2'b10 : 2'b01);
    else passes++;
    tick();
  endtask

  task automatic test_timeout();
    int high_cycles;
    high_cycles = 0;
    data_load = 1'b1; data_address = 32'h600; data_size = 2'b10;
    tick();
    data_load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (ext_read_request === 1'b1) high_cycles++;
      tick();
    end
    checks++;
    if (high_cycles != 4 || ext_read_request !== 1'b0)
      $display("FAIL timeout_request_len: high=%0d then rd=%b expected 4 then 0", high_cycles, ext_read_request);
    else passes++;
    checks++;
    if (data_ready !== 1'b1 || data_error !== 1'b1 || data_load_data !== 32'd0)
      $display("FAIL timeout_resp: rdy=%b err=%b data=%h expected 1 1 00000000",
               data_ready, data_error, data_load_data);
    else passes++;
    tick();
    checks++;
    if (data_ready !== 1'b0 || data_error !== 1'b0)
      $display("FAIL timeout_pulse: rdy=%b err=%b expected 0 0", data_ready, data_error);
    else passes++;
  endtask

  task automatic test_reset_mid_access();
    data_store = 1'b1; data_address = 32'h800; data_size = 2'b10; data_store_data = 32'h55;
    tick();
    data_store = 1'b0;
    checks++;
    if (ext_write_request !== 1'b1)
      $display("FAIL midreset_busy: wr=%b expected 1", ext_write_request);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({fetch_ready, fetch_data, fetch_error, data_ready, data_load_data, data_error,
         ext_address, ext_write_data, ext_write_strobe, ext_read_request, ext_write_request} !== '0)
      $display("FAIL midreset_async: wr=%b rd=%b fdata=%h expected 0 0 00000000",
               ext_write_request, ext_read_request, fetch_data);
    else passes++;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (data_ready !== 1'b0 || fetch_ready !== 1'b0 || ext_write_request !== 1'b0)
      $display("FAIL midreset_no_ready: drdy=%b frdy=%b wr=%b expected 0 0 0",
               data_ready, fetch_ready, ext_write_request);
    else passes++;
    fetch_request = 1'b1; fetch_address = 32'h700;
    tick();
    fetch_request = 1'b0;
    checks++;
    if (ext_address !== 32'h700 || ext_read_request !== 1'b1)
      $display("FAIL after_reset_bus: addr=%h rd=%b expected 00000700 1", ext_address, ext_read_request);
    else passes++;
    ext_ready = 1'b1; ext_read_data = 32'hDEAD_BEEF;
    tick();
    ext_ready = 1'b0;
    checks++;
    if (fetch_ready !== 1'b1 || fetch_data !== 32'hDEADBEEF || fetch_error !== 1'b0)
      $display("FAIL after_reset_resp: rdy=%b data=%h err=%b expected 1 deadbeef 0",
               fetch_ready, fetch_data, fetch_error);
    else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_arbitration();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
